// File: rtl/base_rr_sched.sv
// Round-robin scheduler granting one shared resource to one owner at a time until done.
// Optional ownership timeout is compiled in with BASE_RR_SCHED_TIMEOUT_EN.
module base_rr_sched #(
    parameter int enc_width = 2,
    parameter int ways      = 2**enc_width,
    parameter int timeout   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [0:ways-1]      i_req_v,
    output logic [0:ways-1]      o_req_r,
    input  logic                 i_done_v,
    output logic                 o_gnt_v,
    output logic [0:enc_width-1] o_gnt_enc,
    output logic [0:ways-1]      o_gnt_dec,
    output logic                 o_busy,
    output logic                 o_timeout
);

    localparam logic [0:0]           IDLE    = 1'b0;
    localparam logic [0:0]           OWN     = 1'b1;
    localparam logic [enc_width-1:0] ENC_ONE = enc_width'(1'b1);

    logic [0:0]           state_r;
    logic [enc_width-1:0] ptr_r;
    logic [enc_width-1:0] gnt_enc_r;
    logic [0:ways-1]      gnt_dec_r;
    logic                 gnt_v_r;
    logic [enc_width-1:0] idx_s;
    logic [enc_width-1:0] win_s;
    logic                 found_s;
    logic [0:ways-1]      req_r_s;
    logic                 accept_s;
    logic                 done_exit_s;
    logic                 to_exit_s;
    logic                 exit_s;

    // Rotating-priority search starting at ptr; ready is held low while reset is asserted.
    always_comb begin
        idx_s   = ptr_r;
        win_s   = ptr_r;
        found_s = 1'b0;
        req_r_s = '0;
        for (int i = 0; i < ways; i++) begin
            idx_s = ptr_r + enc_width'(i);
            if (!found_s && i_req_v[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        if (reset_n && (state_r == IDLE) && found_s) begin
            req_r_s[win_s] = 1'b1;
        end else begin
            req_r_s = '0;
        end
    end

    assign accept_s    = |req_r_s;
    assign done_exit_s = (state_r == OWN) && i_done_v;
    assign exit_s      = done_exit_s || to_exit_s;

    // Ownership FSM: grant on acceptance, release and advance the pointer on done or timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            gnt_v_r   <= 1'b0;
            gnt_enc_r <= '0;
            gnt_dec_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r   <= OWN;
                        gnt_v_r   <= 1'b1;
                        gnt_enc_r <= win_s;
                        gnt_dec_r <= req_r_s;
                    end
                end
                OWN: begin
                    if (exit_s) begin
                        state_r   <= IDLE;
                        gnt_v_r   <= 1'b0;
                        gnt_dec_r <= '0;
                        ptr_r     <= gnt_enc_r + ENC_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    gnt_v_r   <= 1'b0;
                    gnt_dec_r <= '0;
                end
            endcase
        end
    end

`ifdef BASE_RR_SCHED_TIMEOUT_EN
    localparam logic [15:0] LAST_CNT = 16'(timeout) - 16'd1;

    logic [15:0] cnt_r;
    logic        timeout_r;

    // Done wins over an expiry in the same cycle, so expiry is only taken without done.
    assign to_exit_s = (state_r == OWN) && !i_done_v && (cnt_r == LAST_CNT);

    // Ownership age counter and the one-cycle revoke pulse aligned with the grant falling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r     <= 16'd0;
            timeout_r <= 1'b0;
        end else begin
            if (accept_s) begin
                cnt_r <= 16'd0;
            end else if ((state_r == OWN) && !i_done_v) begin
                cnt_r <= cnt_r + 16'd1;
            end
            timeout_r <= to_exit_s;
        end
    end

    assign o_timeout = timeout_r;
`else
    assign to_exit_s = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_req_r   = req_r_s;
    assign o_gnt_v   = gnt_v_r;
    assign o_gnt_enc = gnt_enc_r;
    assign o_gnt_dec = gnt_dec_r;
    assign o_busy    = gnt_v_r;

endmodule

// File: doc/base_rr_sched.md
# base_rr_sched

Round-robin scheduler that shares one downstream resource among `2**enc_width` requesters. Each winner holds ownership until it signals completion. The block registers the winner as an encoded index plus a one-hot select. The one-hot select drives the per-requester enables of the shared datapath, such as the mux select or the per-port decode. It sits in front of any single-owner resource in the AFU, for example a shared command port or a DMA engine.

## Interface
- `enc_width`, default 2: width of the encoded grant index.
- `ways`, default `2**enc_width`: number of requesters. Derived from `enc_width`; not overridden.
- `timeout`, default 255: ownership timeout in cycles. Only used with `BASE_RR_SCHED_TIMEOUT_EN`. Legal range is 1..65535.
- `clk`, input, 1: clock. All logic is on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `i_req_v`, input, `[0:ways-1]`: request valid. Bit i belongs to requester i.
- `o_req_r`, output, `[0:ways-1]`: request ready. Combinational, at most one bit set.
- `i_done_v`, input, 1: the current owner has finished. One-cycle pulse.
- `o_gnt_v`, output, 1: ownership is active (registered).
- `o_gnt_enc`, output, `[0:enc_width-1]`: index of the owner (registered).
- `o_gnt_dec`, output, `[0:ways-1]`: one-hot of `o_gnt_enc`, gated by `o_gnt_v`. Registered.
- `o_busy`, output, 1: equals `o_gnt_v`.
- `o_timeout`, output, 1: one-cycle pulse when ownership is revoked by timeout. Tied to 0 when the feature is compiled out.

## Operation
- **States.** Two states, IDLE and OWN.
- **Pointer.** `ptr` has width `enc_width` and gives the highest-priority requester.
- **IDLE, winner selection.**
  - The winner is the first set bit of `i_req_v` scanning `ptr, ptr+1, …` modulo `ways`.
  - `o_req_r` is the one-hot of the winner. It is all-zero when `i_req_v` is zero.
  - The request is accepted when `i_req_v[w] & o_req_r[w]`.
- **IDLE to OWN.** On acceptance:
  - `o_gnt_enc` is loaded with w.
  - `o_gnt_dec[w]` and `o_gnt_v` are set.
- **OWN.**
  - `o_req_r` is all-zero.
  - `i_req_v` changes are ignored.
  - `o_gnt_*` are held stable.
- **OWN to IDLE, on `i_done_v`:**
  - `o_gnt_v` and `o_gnt_dec` are cleared.
  - `ptr` is set to `owner+1` (wraps `ways-1` to 0).
  - `o_gnt_enc` keeps its last value.
- **`i_done_v` in IDLE** is ignored.
- **Requesters.** A requester must hold `i_req_v` until it sees `o_req_r`. Dropping the request earlier is legal, and that requester is simply not selected.
- **Reset values.**
  - State is IDLE.
  - `ptr` = 0.
  - `o_gnt_v` = 0, `o_gnt_enc` = 0, `o_gnt_dec` = 0, `o_busy` = 0, `o_timeout` = 0.
- **Reset asserted mid-ownership** forces all of the reset values immediately. Pending requests are re-arbitrated from `ptr` = 0 after release.

## Timing
- Request accepted in cycle N: `o_gnt_v`/`o_gnt_dec` are valid in cycle N+1.
- `i_done_v` in cycle M: `o_gnt_v` = 0 in M+1. The next `o_req_r` can assert combinationally in M+1, so the next grant is visible in M+2.
- Minimum grant-to-grant spacing is 2 cycles, with one idle cycle between owners.
- `o_req_r` is combinational from `i_req_v`, state and `ptr`. The requester side must not loop it back combinationally into `i_req_v`.
- A single requester asserted continuously is granted every 2 cycles when done is immediate.

## Configuration
- Macro: `BASE_RR_SCHED_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to OWN and increments each OWN cycle without `i_done_v`.
  - When the count reaches `timeout-1` without done, the block returns to IDLE next cycle exactly as if done had occurred: `ptr` advances and `o_timeout` pulses for 1 cycle, aligned with `o_gnt_v` falling.
  - If `i_done_v` and timeout expiry coincide, done wins and there is no `o_timeout` pulse.
- **Undefined:** no counter is built, `o_timeout` is 0, and ownership is unbounded.

## Test plan
- **Reset:** `reset_n` low, all requests high. Required response: `o_req_r` = 0 and all outputs 0. After release, requester 0 is granted: `o_gnt_enc` = 0 and `o_gnt_dec` = 1000 (ways = 4).
- **Fairness:** all 4 requests held high, done 3 cycles after each grant. Required response: grant order 0,1,2,3,0, with `o_gnt_v` low exactly 1 cycle between owners.
- **Pointer skip:** `ptr` = 2 (after owner 1 finishes), requests at bits 0 and 3. Required response: 3 is granted, then 0.
- **Wrap/async reset:** owner 3 finishes, then `ptr` = 0. Assert `reset_n` low mid-OWN with owner 2. Required response: `o_gnt_v` = 0 without waiting for a clock edge, and `ptr` = 0.
- **Ignored events:** `i_done_v` pulsed in IDLE with no requests. Required response: no state change. Request bits changed during OWN do not disturb `o_gnt_enc`.
- **Timeout (macro defined, `timeout` = 4):** grant with no done. Required response: `o_gnt_v` falls 4 cycles after rising, with `o_timeout` high for that 1 cycle. Repeat with done coincident with the final count: no `o_timeout`.
